// File: rtl/srt_quotient_converter_if.sv
// Digit-in / quotient-out handshake bundle for the SRT on-the-fly quotient converter.
// rem_neg is present only when SRT_REM_CORRECT_EN is defined.
interface srt_quotient_converter_if #(
  parameter int QW = 8
);
  logic          digit_valid;
  logic          digit_ready;
  logic [2:0]    q_digit;
`ifdef SRT_REM_CORRECT_EN
  logic          rem_neg;
`endif
  logic          q_valid;
  logic          q_ready;
  logic [QW-1:0] quotient;

`ifdef SRT_REM_CORRECT_EN
  modport master (output digit_valid, q_digit, rem_neg, q_ready,
                  input  digit_ready, q_valid, quotient);
  modport slave  (input  digit_valid, q_digit, rem_neg, q_ready,
                  output digit_ready, q_valid, quotient);
`else
  modport master (output digit_valid, q_digit, q_ready,
                  input  digit_ready, q_valid, quotient);
  modport slave  (input  digit_valid, q_digit, q_ready,
                  output digit_ready, q_valid, quotient);
`endif
endinterface

// File: rtl/srt_quotient_converter.sv
// On-the-fly radix-4 SRT quotient converter: keeps Q and QM=Q-1 so each digit is a shift+append.
// Optional feature macro: SRT_REM_CORRECT_EN (select QM when the final remainder is negative).
module srt_quotient_converter #(
  parameter  int NDIGITS = 4,
  localparam int QW      = 2 * NDIGITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic err,
  srt_quotient_converter_if.slave bus
);

  localparam int CW = (NDIGITS > 2) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state;
  logic [QW-1:0] q_reg;
  logic [QW-1:0] qm_reg;
  logic [CW-1:0] cnt;
  logic [QW-1:0] quotient_reg;
  logic          q_valid_reg;
  logic          err_reg;

  logic          digit_illegal;
  logic [2:0]    d_eff;
  logic [2:0]    d_minus;
  logic [QW-1:0] q_next;
  logic [QW-1:0] qm_next;
  logic [QW-1:0] result_next;
  logic          accept;

  // Appended low digit of Q is d mod 4 and of QM is (d-1) mod 4; only the shifted source differs.
  always_comb begin
    digit_illegal = (bus.q_digit == 3'b011) || (bus.q_digit == 3'b100);
    d_eff         = digit_illegal ? 3'b000 : bus.q_digit;
    d_minus       = d_eff - 3'd1;
    q_next        = d_eff[2] ? {qm_reg[QW-3:0], d_eff[1:0]} : {q_reg[QW-3:0], d_eff[1:0]};
    qm_next       = (d_eff[2] || (d_eff == 3'b000)) ? {qm_reg[QW-3:0], d_minus[1:0]}
                                                    : {q_reg[QW-3:0], d_minus[1:0]};
`ifdef SRT_REM_CORRECT_EN
    result_next   = bus.rem_neg ? qm_next : q_next;
`else
    result_next   = q_next;
`endif
    accept        = bus.digit_valid && (state == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      q_reg        <= '0;
      qm_reg       <= '1;
      cnt          <= '0;
      quotient_reg <= '0;
      q_valid_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else if (start) begin
      state       <= ACCUM;
      q_reg       <= '0;
      qm_reg      <= '1;
      cnt         <= '0;
      q_valid_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ACCUM: begin
          if (accept) begin
            q_reg  <= q_next;
            qm_reg <= qm_next;
            cnt    <= cnt + 1'b1;
            if (digit_illegal)
              err_reg <= 1'b1;
            if (cnt == LAST) begin
              state        <= DONE;
              quotient_reg <= result_next;
              q_valid_reg  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.q_ready) begin
            state       <= IDLE;
            q_valid_reg <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.digit_ready = (state == ACCUM);
  assign bus.q_valid     = q_valid_reg;
  assign bus.quotient    = quotient_reg;
  assign busy            = (state != IDLE);
  assign err             = err_reg;

endmodule

// File: tb/tb_srt_quotient_converter.sv
// Randomized self-checking bench for srt_quotient_converter against a digit-weight arithmetic model.
// Honours SRT_REM_CORRECT_EN when it is defined for the build.
module tb_srt_quotient_converter;

  localparam int NDIG = 4;
  localparam int QW   = 2 * NDIG;
`ifdef SRT_REM_CORRECT_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  typedef logic [2:0] digits_t [NDIG];

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic err;
  int   checkCount;
  int   passCount;

  srt_quotient_converter_if #(.QW(QW)) bus ();

  srt_quotient_converter #(.NDIGITS(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .err   (err),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed digit value; the two illegal codes count as zero.
  function automatic int digitValue(input logic [2:0] code);
    int v;
    v = int'($signed(code));
    if (v == 3 || v == -4) v = 0;
    return v;
  endfunction

  function automatic logic [QW-1:0] refQuotient(input digits_t codes, input bit remNeg);
    int acc;
    acc = 0;
    for (int i = 0; i < NDIG; i++) acc = acc * 4 + digitValue(codes[i]);
    if (remNeg) acc = acc - 1;
    return QW'(acc);
  endfunction

  function automatic bit refErr(input digits_t codes);
    bit e;
    e = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (codes[i] == 3'b011 || codes[i] == 3'b100) e = 1'b1;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checkCount++;
    if (got !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, expected, $time);
    else
      passCount++;
  endtask

  task automatic setRemNeg(input bit v);
`ifdef SRT_REM_CORRECT_EN
    bus.rem_neg = v;
`else
    if (v) begin end
`endif
  endtask

  task automatic applyStimulus(input digits_t codes, input bit remNeg, input int holdCycles,
                               input bit bubbles);
    logic [QW-1:0] expQ;
    bit            expErr;
    expQ   = refQuotient(codes, remNeg & REM_EN);
    expErr = refErr(codes);

    // A digit presented alongside start must be ignored.
    @(posedge clk); #1;
    start           = 1'b1;
    bus.digit_valid = 1'b1;
    bus.q_digit     = 3'b010;
    bus.q_ready     = 1'b0;
    @(posedge clk); #1;
    start           = 1'b0;
    bus.digit_valid = 1'b0;
    checkOutput("ready_after_start", 32'(bus.digit_ready), 32'd1);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("err_cleared_by_start", 32'(err), 32'd0);

    for (int i = 0; i < NDIG; i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          bus.digit_valid = 1'b0;
          bus.q_digit     = 3'($urandom);
          @(posedge clk); #1;
        end
      end
      bus.digit_valid = 1'b1;
      bus.q_digit     = codes[i];
      setRemNeg((i == NDIG - 1) ? remNeg : ~remNeg);
      @(posedge clk); #1;
      if (i < NDIG - 1)
        checkOutput("no_early_valid", 32'(bus.q_valid), 32'd0);
    end
    bus.digit_valid = 1'b0;
    setRemNeg(~remNeg);
    checkOutput("q_valid_after_last", 32'(bus.q_valid), 32'd1);
    checkOutput("quotient", 32'(bus.quotient), 32'(expQ));
    checkOutput("err", 32'(err), 32'(expErr));
    checkOutput("ready_low_in_done", 32'(bus.digit_ready), 32'd0);

    // Extra digits offered while waiting must not disturb the held result.
    repeat (holdCycles) begin
      bus.digit_valid = 1'b1;
      bus.q_digit     = 3'($urandom);
      @(posedge clk); #1;
      checkOutput("hold_q_valid", 32'(bus.q_valid), 32'd1);
      checkOutput("hold_quotient", 32'(bus.quotient), 32'(expQ));
      checkOutput("hold_ready_low", 32'(bus.digit_ready), 32'd0);
    end
    bus.digit_valid = 1'b0;
    bus.q_ready     = 1'b1;
    @(posedge clk); #1;
    bus.q_ready     = 1'b0;
    checkOutput("q_valid_dropped", 32'(bus.q_valid), 32'd0);
    checkOutput("busy_dropped", 32'(busy), 32'd0);
    checkOutput("err_sticky", 32'(err), 32'(expErr));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_digit_ready"}, 32'(bus.digit_ready), 32'd0);
    checkOutput({tag, "_q_valid"}, 32'(bus.q_valid), 32'd0);
    checkOutput({tag, "_quotient"}, 32'(bus.quotient), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    digits_t d;
    checkCount      = 0;
    passCount       = 0;
    rst_n           = 1'b0;
    start           = 1'b0;
    bus.digit_valid = 1'b0;
    bus.q_digit     = 3'b000;
    bus.q_ready     = 1'b0;
    setRemNeg(1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    d = '{3'b010, 3'b001, 3'b000, 3'b111};
    applyStimulus(d, 1'b0, 0, 1'b0);
    d = '{3'b111, 3'b000, 3'b000, 3'b000};
    applyStimulus(d, 1'b0, 0, 1'b0);
    d = '{3'b010, 3'b010, 3'b010, 3'b010};
    applyStimulus(d, 1'b0, 3, 1'b0);
    d = '{3'b110, 3'b110, 3'b110, 3'b110};
    applyStimulus(d, 1'b0, 0, 1'b0);
    d = '{3'b000, 3'b011, 3'b000, 3'b000};
    applyStimulus(d, 1'b0, 1, 1'b0);
    d = '{3'b100, 3'b001, 3'b000, 3'b000};
    applyStimulus(d, 1'b0, 0, 1'b0);

    $display("[TB] restart mid-accumulation");
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start           = 1'b0;
    bus.digit_valid = 1'b1;
    bus.q_digit     = 3'b001;
    repeat (2) @(posedge clk);
    #1;
    bus.digit_valid = 1'b0;
    d = '{3'b000, 3'b000, 3'b000, 3'b001};
    applyStimulus(d, 1'b0, 0, 1'b0);

    $display("[TB] asynchronous reset mid-operation");
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start           = 1'b0;
    bus.digit_valid = 1'b1;
    bus.q_digit     = 3'b011;
    repeat (2) @(posedge clk);
    #1;
    bus.digit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkResetState("async_reset");
    #1;
    rst_n = 1'b1;
    d = '{3'b000, 3'b000, 3'b000, 3'b001};
    applyStimulus(d, 1'b0, 0, 1'b0);
    applyStimulus(d, 1'b1, 0, 1'b0);

    $display("[TB] randomized vectors");
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NDIG; i++) begin
        if ($urandom_range(0, 9) == 0)
          d[i] = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b100;
        else
          d[i] = 3'(int'($urandom_range(0, 4)) - 2);
      end
      applyStimulus(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
